// File: rtl/rom_alu_pkg.sv
// Shared definitions for the ROM -> ALU -> register-file datapath:
// op encodings, sequencer state encodings and the default ROM contents.
package rom_alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    // Default ROM table; any address beyond the table reads zero.
    function automatic int unsigned rom_word(input int unsigned a);
        case (a)
            32'd0:   return 32'd0;
            32'd1:   return 32'd12;
            32'd2:   return 32'd6;
            32'd3:   return 32'd7;
            32'd4:   return 32'd8;
            32'd5:   return 32'd1;
            32'd6:   return 32'd13;
            32'd7:   return 32'd14;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/sys_rom.sv
// Synchronous-read ROM with registered output, filled from the default
// table in rom_alu_pkg. Values are truncated/zero-extended to DATA_W.
module sys_rom
    import rom_alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    // Registered read: data for addr appears after the next rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= DATA_W'(rom_word(32'(addr)));
        end
    end

endmodule

// File: rtl/rom_alu_regfile.sv
// ROM -> ALU -> register-file datapath driven by a five-state sequencer.
// Optional feature macro: SUB_SAT_EN (subtract clamps to zero when B > A;
// without it subtract wraps modulo 2**RES_W).
//
// Handshake: start is sampled only while the sequencer is IDLE; a sampled
// start latches op/addr1/addr2/dest_addr and raises busy at that edge (k).
// done is a single-cycle pulse asserted at edge k+4 together with the result
// and register-file write, and busy drops at the same edge. A start seen while
// busy is dropped, not queued. The earliest next accepted start is edge k+5.
module rom_alu_regfile
    import rom_alu_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  ADDR_W = 3,
    parameter int  RF_AW  = 3,
    localparam int RES_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [RF_AW-1:0]  dest_addr,
    input  logic [RF_AW-1:0]  rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output state_t            state
);

    state_t             state_q, state_d;
    logic               accept;
    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  addr1_q, addr2_q;
    logic [RF_AW-1:0]   dest_q;
    logic [ADDR_W-1:0]  rom_addr;
    logic [DATA_W-1:0]  rom_q;
    logic [DATA_W-1:0]  a_q;
    logic [RES_W-1:0]   a_ext, b_ext;
    logic [RES_W-1:0]   alu_res, alu_q;
    logic [RES_W-1:0]   rf [2**RF_AW];

    sys_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (rom_addr),
        .q    (rom_q)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, request acceptance and ROM address selection.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rom_addr = addr1_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                rom_addr = addr1_q;
                state_d  = S_RD_B;
            end
            S_RD_B: begin
                rom_addr = addr2_q;
                state_d  = S_EXEC;
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU on zero-extended operands: A is held in a_q, B is the live ROM output.
    always_comb begin
        a_ext = {{(RES_W-DATA_W){1'b0}}, a_q};
        b_ext = {{(RES_W-DATA_W){1'b0}}, rom_q};
        case (op_q)
            OP_ADD: alu_res = a_ext + b_ext;
`ifdef SUB_SAT_EN
            OP_SUB: alu_res = (b_ext > a_ext) ? '0 : (a_ext - b_ext);
`else
            OP_SUB: alu_res = a_ext - b_ext;
`endif
            OP_MUL: alu_res = a_ext * b_ext;
            default: alu_res = a_ext;
        endcase
    end

    // Request latch, operand capture, ALU register and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_ADD;
            addr1_q <= '0;
            addr2_q <= '0;
            dest_q  <= '0;
            a_q     <= '0;
            alu_q   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q    <= op;
                addr1_q <= addr1;
                addr2_q <= addr2;
                dest_q  <= dest_addr;
                busy    <= 1'b1;
            end
            if (state_q == S_RD_B) begin
                a_q <= rom_q;
            end
            if (state_q == S_EXEC) begin
                alu_q <= alu_res;
            end
            if (state_q == S_WB) begin
                result <= alu_q;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
        end
    end

    // Register file: cleared on reset, written once per request on leaving WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**RF_AW; i++) begin
                rf[i] <= '0;
            end
        end else if (state_q == S_WB) begin
            rf[dest_q] <= alu_q;
        end
    end

    assign rd_data = rf[rd_addr];
    assign state   = state_q;

endmodule

// File: tb/tb_rom_alu_regfile.sv
// Self-checking bench for rom_alu_regfile with default parameters.
// A request-level model predicts busy/done/result/rd_data each cycle;
// directed scenarios pin the model with hand-computed values, then a
// randomized phase exercises overlapping starts and readback.
module tb_rom_alu_regfile;
    import rom_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [2:0] addr1, addr2;
    logic [2:0] dest_addr, rd_addr;
    logic [7:0] rd_data, result;
    logic       busy, done;
    state_t     state;

    int vectors     = 0;
    int miscompares = 0;

    rom_alu_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .addr1     (addr1),
        .addr2     (addr2),
        .dest_addr (dest_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .state     (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model
    int         rom_m [8] = '{0, 12, 6, 7, 8, 1, 13, 14};
    logic [7:0] rf_m [8]  = '{default: 8'h00};
    logic [7:0] result_m  = 8'h00;
    logic       done_m    = 1'b0;
    int         pend      = 0;
    int         req_op, req_a, req_b, req_d;

    function automatic logic [7:0] model_alu(input int o, input int a, input int b);
        int r;
        case (o)
            0: r = a + b;
`ifdef SUB_SAT_EN
            1: r = (b > a) ? 0 : a - b;
`else
            1: r = a - b;
`endif
            2: r = a * b;
            default: r = a;
        endcase
        return 8'(r);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 0;
            done_m   <= 1'b0;
            result_m <= 8'h00;
            for (int i = 0; i < 8; i++) rf_m[i] <= 8'h00;
        end else begin
            done_m <= 1'b0;
            if (pend == 0) begin
                if (start) begin
                    pend   <= 4;
                    req_op <= int'(op);
                    req_a  <= rom_m[addr1];
                    req_b  <= rom_m[addr2];
                    req_d  <= int'(dest_addr);
                end
            end else begin
                pend <= pend - 1;
                if (pend == 1) begin
                    result_m    <= model_alu(req_op, req_a, req_b);
                    rf_m[req_d] <= model_alu(req_op, req_a, req_b);
                    done_m      <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("busy", busy, (pend != 0));
            check("done", done, done_m);
            check("result", result, result_m);
            check("rd_data", rd_data, rf_m[rd_addr]);
        end
    end

    // Driver tasks
    task automatic drive_start(input logic [1:0] o, input int a1, input int a2, input int d);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        addr1     = 3'(a1);
        addr2     = 3'(a2);
        dest_addr = 3'(d);
        @(negedge clk);
        start     = 1'b0;
        op        = 2'($urandom_range(0, 3));
        addr1     = 3'($urandom_range(0, 7));
        addr2     = 3'($urandom_range(0, 7));
        dest_addr = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check({name, "_latency"}, lat, 5);
    endtask

    task automatic read_check(input string name, input int a, input logic [7:0] exp);
        rd_addr = 3'(a);
        #1;
        check(name, rd_data, exp);
    endtask

    int cnt;

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00;
        addr1 = '0; addr2 = '0; dest_addr = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", state, S_IDLE);
        for (int i = 0; i < 8; i++) read_check("reset_rf", i, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // add: 8 + 1
        drive_start(OP_ADD, 4, 5, 0);
        wait_done("add");
        check("add_result", result, 8'd9);
        read_check("add_rf0", 0, 8'd9);

        // mul: 12 * 7
        drive_start(OP_MUL, 1, 3, 1);
        wait_done("mul");
        check("mul_result", result, 8'h54);
        read_check("mul_rf1", 1, 8'h54);
        read_check("mul_rf0_kept", 0, 8'd9);

        // sub: 1 - 8
        drive_start(OP_SUB, 5, 4, 2);
        wait_done("sub");
`ifdef SUB_SAT_EN
        check("sub_result", result, 8'h00);
        read_check("sub_rf2", 2, 8'h00);
`else
        check("sub_result", result, 8'hF9);
        read_check("sub_rf2", 2, 8'hF9);
`endif

        // hazard: pass 13 into rf[0] while reading rf[0]
        @(negedge clk);
        rd_addr = 3'd0;
        start = 1'b1; op = OP_PASS; addr1 = 3'd6; addr2 = 3'd2; dest_addr = 3'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("hazard_old", rd_data, 8'd9);
        @(negedge clk);
        #2;
        check("hazard_new", rd_data, 8'd13);
        check("pass_result", result, 8'd13);

        // busy: starts during an in-flight request are dropped
        @(negedge clk);
        start = 1'b1; op = OP_ADD; addr1 = 3'd1; addr2 = 3'd2; dest_addr = 3'd3;
        @(negedge clk);
        op = OP_PASS; addr1 = 3'd7; dest_addr = 3'd4;
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            if (done) cnt++;
        end
        check("busy_done_count", cnt, 1);
        check("busy_result", result, 8'd18);
        read_check("busy_rf3", 3, 8'd18);
        read_check("busy_rf4", 4, 8'd0);

        // abort: reset two edges into a request
        @(negedge clk);
        start = 1'b1; op = OP_ADD; addr1 = 3'd7; addr2 = 3'd7; dest_addr = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        for (int i = 0; i < 8; i++) read_check("abort_rf", i, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            if (done) cnt++;
        end
        check("abort_no_done", cnt, 0);
        read_check("abort_rf5", 5, 8'h00);

        // randomized traffic, including starts while busy
        repeat (1500) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            op        = 2'($urandom_range(0, 3));
            addr1     = 3'($urandom_range(0, 7));
            addr2     = 3'($urandom_range(0, 7));
            dest_addr = 3'($urandom_range(0, 7));
            rd_addr   = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
